pc_redirect_ctrl: RTL and testbench
===================================

# pc_redirect_ctrl

Program-counter sequencer for the MIPS32 fetch stage: holds the current fetch PC and decides each cycle whether the next PC is sequential, a taken branch from EX, or a jump from ID. It produces the 2-bit select and the three candidate addresses consumed by the PC select mux, plus the IF-stage flush. Redirects that arrive during a pipeline stall are buffered and applied when the stall releases.

## Interface
- data_bits, 31: MSB index of all address buses; width is data_bits+1 (32 bits).
- RESET_PC, 32'h0000_0000: PC loaded by reset.

- clk  in  1  rising-edge clock
- rst  in  1  synchronous, active-high reset
- stall  in  1  hazard unit hold; PC and outputs frozen when high
- br_valid  in  1  EX has resolved a branch this cycle
- br_taken  in  1  qualifier for br_valid
- br_target  in  data_bits+1  branch target address
- jmp_valid  in  1  ID decoded J/JAL/JR this cycle
- jmp_target  in  data_bits+1  jump target address
- pc  out  data_bits+1  current fetch PC
- sel  out  2  mux select: 00 seq, 01 branch, 1x jump
- seq_addr / br_addr / jmp_addr  out  data_bits+1 each  mux candidates
- fetch_valid  out  1  pc is a valid fetch address
- flush  out  1  kill instruction currently in IF
- addr_err  out  1  sticky misaligned-target flag

## Operation
- Redirect request this cycle: br = br_valid & br_taken; jmp = jmp_valid. br outranks jmp (older instruction); a jmp coincident with br is discarded.
- FSM states: RUN, PEND.
  - RUN, stall=0: pc <= br ? br_target : jmp ? jmp_target : pc+4; sel/candidates updated to match the choice.
  - RUN, stall=1, br or jmp: capture kind+target into pend regs, go PEND; pc held.
  - PEND, stall=1: new br overwrites a pending jmp; new jmp while pending is ignored; pending br is never overwritten.
  - PEND, stall=0: apply pending target (a br arriving this same cycle overrides a pending jmp); return to RUN.
- Candidates: seq_addr = pc+4 (wraps modulo 2^(data_bits+1)), br_addr/jmp_addr = last applied targets.
- Misaligned target (bits[1:0] != 0): bits[1:0] forced to 00 before use; addr_err set, cleared only by rst.
- flush: 1 in the cycle a redirect is applied (RUN or PEND exit), else 0 (see Configuration).

## Timing
- All outputs registered; redirect sampled at edge N appears on pc at N+1 (1-cycle latency); a buffered redirect appears the cycle after stall falls.
- Reset values: pc=RESET_PC, sel=00, seq_addr=RESET_PC+4, br_addr=jmp_addr=0, fetch_valid=0, flush=0, addr_err=0, state RUN, pending cleared.
- fetch_valid rises on the first edge with rst=0 and stays 1.
- rst during PEND discards the pending redirect; rst outranks stall.
- stall=1 freezes pc, sel, candidates, flush=0.

## Configuration
- PCREDIR_DELAY_SLOT_EN defined: MIPS delay slot honoured; the instruction at pc+4 after a branch/jump is executed, flush never asserts; a redirect is applied after the slot PC has been issued (one extra sequential fetch, tracked by a slot-pending bit; stall holds it).
- Undefined: no delay slot; flush=1 in the redirect cycle, redirect applied immediately.

## Test plan
- Reset: rst=1 two cycles, RESET_PC=0x0040_0000 -> pc=0x0040_0000, fetch_valid=0; after release pc steps 0x0040_0004, 0x0040_0008, sel=00.
- Taken branch: br_valid=br_taken=1, br_target=0x100 at pc=0x20 -> next pc=0x100, sel=01, flush=1 (no macro); with macro pc=0x24 then 0x100, flush=0.
- Simultaneous br (0x200) and jmp (0x300) -> pc=0x200, jmp dropped, sel=01.
- Stall buffering: stall=1, jmp 0x80, then br 0x90 during stall, release -> pc=0x90 one cycle after release; reverse order -> pc=br target.
- Reset in PEND: capture br 0x400 under stall, rst=1 -> pc=RESET_PC, no later jump to 0x400.
- Edge cases: br_target=0x103 -> pc=0x100, addr_err=1 sticky; pc=0xFFFF_FFFC sequential -> 0x0000_0000.

Source files
------------

// File: rtl/pc_redirect_if.sv
// Fetch-PC sequencer bus: redirect requests in from EX/ID/hazard unit, PC and
// PC-mux select/candidates out to the fetch stage.
interface pc_redirect_if #(
    parameter int data_bits = 31
);
    logic               stall;
    logic               br_valid;
    logic               br_taken;
    logic [data_bits:0] br_target;
    logic               jmp_valid;
    logic [data_bits:0] jmp_target;
    logic [data_bits:0] pc;
    logic [1:0]         sel;
    logic [data_bits:0] seq_addr;
    logic [data_bits:0] br_addr;
    logic [data_bits:0] jmp_addr;
    logic               fetch_valid;
    logic               flush;
    logic               addr_err;

    modport master (
        output stall, br_valid, br_taken, br_target, jmp_valid, jmp_target,
        input  pc, sel, seq_addr, br_addr, jmp_addr, fetch_valid, flush, addr_err
    );

    modport slave (
        input  stall, br_valid, br_taken, br_target, jmp_valid, jmp_target,
        output pc, sel, seq_addr, br_addr, jmp_addr, fetch_valid, flush, addr_err
    );
endinterface

// File: rtl/pc_redirect_ctrl.sv
// MIPS32 fetch PC sequencer with stall-buffered branch/jump redirects.
// Define PCREDIR_DELAY_SLOT_EN to fetch the delay slot before a redirect lands.
module pc_redirect_ctrl #(
    parameter int                 data_bits = 31,
    parameter logic [data_bits:0] RESET_PC  = '0
) (
    input logic         clk,
    input logic         rst,
    pc_redirect_if.slave bus
);
    localparam logic [data_bits:0] STEP = {{(data_bits - 2){1'b0}}, 3'b100};

    typedef enum logic {RUN, PEND} state_t;
    state_t state, state_nx;

    logic [data_bits:0] pc_q, seq_q, br_q, jmp_q, pend_tgt;
    logic [1:0]         sel_q;
    logic               fv_q, fl_q, err_q, pend_br;

    logic               go, go_br, cap, cap_br, err_set, flush_nx;
    logic [data_bits:0] go_tgt, cap_tgt, pc_nx, br_nx, jmp_nx;
    logic [1:0]         sel_nx;
    logic               br, jmp;

    function automatic logic [data_bits:0] align(input logic [data_bits:0] a);
        return {a[data_bits:2], 2'b00};
    endfunction

`ifdef PCREDIR_DELAY_SLOT_EN
    logic               slot_q, slot_br, slot_nx, slot_br_nx;
    logic [data_bits:0] slot_tgt, slot_tgt_nx;
    // The slot instruction cannot itself redirect, so requests are masked then.
    assign br  = bus.br_valid & bus.br_taken & ~slot_q;
    assign jmp = bus.jmp_valid & ~slot_q;
`else
    assign br  = bus.br_valid & bus.br_taken;
    assign jmp = bus.jmp_valid;
`endif

    always_ff @(posedge clk) begin
        if (rst) state <= RUN;
        else     state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        case (state)
            RUN:  if (bus.stall && (br || jmp)) state_nx = PEND;
            PEND: if (!bus.stall) state_nx = RUN;
            default: state_nx = RUN;
        endcase
    end

    // Redirect arbitration: br outranks jmp; a pending br is never displaced.
    always_comb begin
        go      = 1'b0;
        go_br   = 1'b0;
        go_tgt  = bus.br_target;
        cap     = 1'b0;
        cap_br  = pend_br;
        cap_tgt = pend_tgt;
        if (!bus.stall) begin
            if (state == PEND) begin
                go = 1'b1;
                if (!pend_br && br) begin
                    go_br = 1'b1;
                end else begin
                    go_br  = pend_br;
                    go_tgt = pend_tgt;
                end
            end else if (br) begin
                go    = 1'b1;
                go_br = 1'b1;
            end else if (jmp) begin
                go     = 1'b1;
                go_tgt = bus.jmp_target;
            end
        end else if (state == RUN) begin
            if (br) begin
                cap = 1'b1; cap_br = 1'b1; cap_tgt = bus.br_target;
            end else if (jmp) begin
                cap = 1'b1; cap_br = 1'b0; cap_tgt = bus.jmp_target;
            end
        end else if (!pend_br && br) begin
            cap = 1'b1; cap_br = 1'b1; cap_tgt = bus.br_target;
        end
        err_set = (cap && |cap_tgt[1:0]) || (go && |go_tgt[1:0]);
    end

    always_comb begin
        pc_nx    = pc_q + STEP;
        sel_nx   = 2'b00;
        flush_nx = 1'b0;
        br_nx    = br_q;
        jmp_nx   = jmp_q;
`ifdef PCREDIR_DELAY_SLOT_EN
        slot_nx     = slot_q;
        slot_br_nx  = slot_br;
        slot_tgt_nx = slot_tgt;
        if (slot_q) begin
            pc_nx   = align(slot_tgt);
            sel_nx  = slot_br ? 2'b01 : 2'b10;
            slot_nx = 1'b0;
            if (slot_br) br_nx = align(slot_tgt);
            else         jmp_nx = align(slot_tgt);
        end else if (go) begin
            slot_nx     = 1'b1;
            slot_br_nx  = go_br;
            slot_tgt_nx = go_tgt;
        end
`else
        if (go) begin
            pc_nx    = align(go_tgt);
            sel_nx   = go_br ? 2'b01 : 2'b10;
            flush_nx = 1'b1;
            if (go_br) br_nx = align(go_tgt);
            else       jmp_nx = align(go_tgt);
        end
`endif
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pc_q     <= RESET_PC;
            seq_q    <= RESET_PC + STEP;
            sel_q    <= 2'b00;
            br_q     <= '0;
            jmp_q    <= '0;
            fv_q     <= 1'b0;
            fl_q     <= 1'b0;
            err_q    <= 1'b0;
            pend_br  <= 1'b0;
            pend_tgt <= '0;
`ifdef PCREDIR_DELAY_SLOT_EN
            slot_q   <= 1'b0;
            slot_br  <= 1'b0;
            slot_tgt <= '0;
`endif
        end else begin
            fv_q <= 1'b1;
            if (err_set) err_q <= 1'b1;
            if (cap) begin
                pend_br  <= cap_br;
                pend_tgt <= cap_tgt;
            end
            if (bus.stall) begin
                fl_q <= 1'b0;
            end else begin
                pc_q  <= pc_nx;
                seq_q <= pc_nx + STEP;
                sel_q <= sel_nx;
                br_q  <= br_nx;
                jmp_q <= jmp_nx;
                fl_q  <= flush_nx;
`ifdef PCREDIR_DELAY_SLOT_EN
                slot_q   <= slot_nx;
                slot_br  <= slot_br_nx;
                slot_tgt <= slot_tgt_nx;
`endif
            end
        end
    end

    assign bus.pc          = pc_q;
    assign bus.sel         = sel_q;
    assign bus.seq_addr    = seq_q;
    assign bus.br_addr     = br_q;
    assign bus.jmp_addr    = jmp_q;
    assign bus.fetch_valid = fv_q;
    assign bus.flush       = fl_q;
    assign bus.addr_err    = err_q;
endmodule

// File: tb/tb_pc_redirect_ctrl.sv
// Randomized check of pc_redirect_ctrl (default build, no delay slot) against
// a cycle-level reference model of the redirect rules.
module tb_pc_redirect_ctrl;
    localparam logic [31:0] RPC = 32'h0040_0000;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_chk = 0;
    int   n_err = 0;

    pc_redirect_if #(.data_bits(31)) bus ();

    pc_redirect_ctrl #(.data_bits(31), .RESET_PC(RPC)) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    always #5 clk = ~clk;

    // reference model state
    logic [31:0] m_pc, m_seq, m_br, m_jmp, p_tgt;
    logic [1:0]  m_sel;
    logic        m_fv, m_fl, m_err, p_has, p_isbr;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h want %h at %0t", tag, got, exp, $time);
        end
    endtask

    // kind: 0 none, 1 branch, 2 jump
    task automatic model(input logic r, input logic s, input logic bv, input logic bt,
                         input logic [31:0] btg, input logic jv, input logic [31:0] jtg);
        int          kind;
        logic [31:0] tgt;
        if (r) begin
            m_pc = RPC; m_seq = RPC + 4; m_sel = 0; m_br = 0; m_jmp = 0;
            m_fv = 0; m_fl = 0; m_err = 0; p_has = 0; p_isbr = 0; p_tgt = 0;
            return;
        end
        m_fv = 1;
        if (s) begin
            m_fl = 0;
            if ((bv && bt) && (!p_has || !p_isbr)) begin
                p_has = 1; p_isbr = 1; p_tgt = btg;
                if (btg[1:0] != 0) m_err = 1;
            end else if (jv && !p_has) begin
                p_has = 1; p_isbr = 0; p_tgt = jtg;
                if (jtg[1:0] != 0) m_err = 1;
            end
            return;
        end
        kind = 0; tgt = 0;
        if (p_has && (p_isbr || !(bv && bt))) begin
            kind = p_isbr ? 1 : 2; tgt = p_tgt;
        end else if (bv && bt) begin
            kind = 1; tgt = btg;
        end else if (jv && !p_has) begin
            kind = 2; tgt = jtg;
        end
        p_has = 0;
        if (kind == 0) begin
            m_pc = m_pc + 4; m_sel = 0; m_fl = 0;
        end else begin
            if (tgt[1:0] != 0) m_err = 1;
            m_pc  = tgt & 32'hFFFF_FFFC;
            m_sel = (kind == 1) ? 2'b01 : 2'b10;
            if (kind == 1) m_br = m_pc; else m_jmp = m_pc;
            m_fl = 1;
        end
        m_seq = m_pc + 4;
    endtask

    task automatic cmp_all();
        chk("pc", bus.pc, m_pc);
        chk("sel", {30'd0, bus.sel}, {30'd0, m_sel});
        chk("seq_addr", bus.seq_addr, m_seq);
        chk("br_addr", bus.br_addr, m_br);
        chk("jmp_addr", bus.jmp_addr, m_jmp);
        chk("fetch_valid", {31'd0, bus.fetch_valid}, {31'd0, m_fv});
        chk("flush", {31'd0, bus.flush}, {31'd0, m_fl});
        chk("addr_err", {31'd0, bus.addr_err}, {31'd0, m_err});
    endtask

    task automatic step(input logic r, input logic s, input logic bv, input logic bt,
                        input logic [31:0] btg, input logic jv, input logic [31:0] jtg);
        @(negedge clk);
        rst = r; bus.stall = s; bus.br_valid = bv; bus.br_taken = bt;
        bus.br_target = btg; bus.jmp_valid = jv; bus.jmp_target = jtg;
        @(posedge clk);
        model(r, s, bv, bt, btg, jv, jtg);
        #1;
        cmp_all();
    endtask

    task automatic idle();
        step(0, 0, 0, 0, 32'h0, 0, 32'h0);
    endtask

    initial begin
        bus.stall = 0; bus.br_valid = 0; bus.br_taken = 0; bus.br_target = 0;
        bus.jmp_valid = 0; bus.jmp_target = 0;

        step(1, 0, 0, 0, 0, 0, 0);
        step(1, 0, 0, 0, 0, 0, 0);
        chk("rst_pc", bus.pc, RPC);
        chk("rst_fv", {31'd0, bus.fetch_valid}, 32'd0);
        chk("rst_seq", bus.seq_addr, 32'h0040_0004);
        idle(); chk("seq1", bus.pc, 32'h0040_0004);
        chk("fv_up", {31'd0, bus.fetch_valid}, 32'd1);
        idle(); chk("seq2", bus.pc, 32'h0040_0008);
        chk("seq_sel", {30'd0, bus.sel}, 32'd0);

        step(0, 0, 0, 0, 0, 1, 32'h20);
        step(0, 0, 1, 1, 32'h100, 0, 0);
        chk("br_pc", bus.pc, 32'h100);
        chk("br_sel", {30'd0, bus.sel}, 32'd1);
        chk("br_flush", {31'd0, bus.flush}, 32'd1);
        step(0, 0, 1, 0, 32'h500, 0, 0);
        chk("not_taken", bus.pc, 32'h104);

        step(0, 0, 1, 1, 32'h200, 1, 32'h300);
        chk("both_pc", bus.pc, 32'h200);
        chk("both_jmp_addr", bus.jmp_addr, 32'h20);

        step(0, 1, 0, 0, 0, 1, 32'h80);
        step(0, 1, 1, 1, 32'h90, 0, 0);
        chk("stall_hold", bus.pc, 32'h200);
        step(0, 1, 0, 0, 0, 0, 0);
        idle(); chk("pend_br_win", bus.pc, 32'h90);

        step(0, 1, 1, 1, 32'hA0, 0, 0);
        step(0, 1, 0, 0, 0, 1, 32'hB0);
        idle(); chk("pend_br_kept", bus.pc, 32'hA0);

        step(0, 1, 1, 1, 32'h400, 0, 0);
        step(1, 1, 0, 0, 0, 0, 0);
        chk("rst_pend", bus.pc, RPC);
        idle(); idle();
        chk("no_stale", bus.pc, 32'h0040_0008);

        step(0, 0, 1, 1, 32'h103, 0, 0);
        chk("mis_pc", bus.pc, 32'h100);
        chk("mis_err", {31'd0, bus.addr_err}, 32'd1);
        idle(); chk("err_sticky", {31'd0, bus.addr_err}, 32'd1);

        step(0, 0, 0, 0, 0, 1, 32'hFFFF_FFFC);
        chk("wrap_seq", bus.seq_addr, 32'h0);
        idle(); chk("wrap_pc", bus.pc, 32'h0);

        for (int i = 0; i < 600; i++) begin
            logic [31:0] bt, jt;
            bt = $urandom & 32'h0000_FFFC;
            jt = $urandom & 32'h0000_FFFC;
            if ($urandom_range(0, 19) == 0) bt[1:0] = 2'($urandom_range(1, 3));
            if ($urandom_range(0, 19) == 0) jt[1:0] = 2'($urandom_range(1, 3));
            step($urandom_range(0, 39) == 0, $urandom_range(0, 9) < 4,
                 $urandom_range(0, 2) == 0, $urandom_range(0, 1) == 1, bt,
                 $urandom_range(0, 3) == 0, jt);
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end
endmodule
